// File: rtl/mc_decoder.sv
// mc_decoder: multicycle instruction decoder and main control FSM for the
// ARM32 core. It sequences fetch, decode, execute, memory and writeback for
// the instruction held in the instruction register. It also produces the
// unconditioned write requests (FlagW, PCS, RegW, MemW) that the
// condition-gating stage later qualifies.
//
// Optional feature macro: DECODER_ILLEGAL_TRAP_EN
//   defined   : Op=11 traps into HALT (illegal=1) until reset.
//   undefined : Op=11 behaves as a 2-cycle NOP; illegal is tied to 0.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   Op, Funct, Rd    instruction fields (held stable for the instruction)
//   FlagW, PCS, RegW, MemW   write requests before condition gating
//   NextPC, IRWrite          PC update strobe / IR load enable (FETCH)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
//                            datapath steering
//   illegal          undefined-opcode indication
module mc_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
`ifdef DECODER_ILLEGAL_TRAP_EN
    ,HALT    = 4'd10
`endif
  } state_e;

  state_e state_q, state_d;

  logic alu_op;
  logic branch;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
`ifdef DECODER_ILLEGAL_TRAP_EN
          default: state_d = HALT;
`else
          default: state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
`ifdef DECODER_ILLEGAL_TRAP_EN
      HALT:     state_d = HALT;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // Moore output decode
  always_comb begin
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    alu_op    = 1'b0;
    branch    = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB:    RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decode; Funct only reaches the outputs while an execute state enables it
  always_comb begin
    ALUControl = 2'b00;
    FlagW      = 2'b00;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = 2'b00;
      endcase
      // C,V are only meaningful for the arithmetic ops
      FlagW[1] = Funct[0];
      FlagW[0] = Funct[0] & ~ALUControl[1];
    end
  end

  assign PCS    = branch | (RegW & (Rd == 4'd15));
  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

`ifdef DECODER_ILLEGAL_TRAP_EN
  assign illegal = (state_q == HALT);
`else
  assign illegal = 1'b0;
`endif

endmodule
